// File: rtl/fifo_rd_streamer_pkg.sv
// Shared types for the fifo read streamer: skid depth, pointer/occupancy types, pointer wrap helper.
package fifo_rd_streamer_pkg;

  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] skid_ptr_t;
  typedef logic [1:0] skid_occ_t;

  function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t p);
    return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// 3-entry circular skid buffer: push writes at wr_ptr, pop advances rd_ptr, dat_o shows the head.
// Head is combinational from registers; push and pop in the same clock leave occupancy unchanged.
module stream_skid_buf
  import fifo_rd_streamer_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_dat_i,
  input  logic              pop_i,
  output skid_occ_t         occ_o,
  output logic [DWIDTH-1:0] dat_o
);

  logic [DWIDTH-1:0] mem_q [SKID_DEPTH];
  skid_ptr_t         wr_ptr_q, wr_ptr_d;
  skid_ptr_t         rd_ptr_q, rd_ptr_d;
  skid_occ_t         occ_q, occ_d;

  always_comb begin
    wr_ptr_d = push_i ? skid_ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i ? skid_ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q + skid_occ_t'(push_i) - skid_occ_t'(pop_i);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o = occ_q;
  assign dat_o = mem_q[rd_ptr_q];

  // The upstream credit check guarantees a free slot for every word in flight.
  push_into_full_a: assert property (@(posedge clk_i) disable iff (arst_i)
    !(push_i && occ_q == skid_occ_t'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Normal-mode fifo read master: rdreq credit logic, 1-clk q capture into a skid buffer, valid/ready out.
// Optional transfer counter on words_o when FIFO_RD_STREAMER_STAT_EN is defined.
module fifo_rd_streamer
  import fifo_rd_streamer_pkg::*;
#(
  parameter int DWIDTH = 8
`ifdef FIFO_RD_STREAMER_STAT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 enable_i,
  input  logic [DWIDTH-1:0]    fifo_q_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rdreq_o,
  output logic [DWIDTH-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i
`ifdef FIFO_RD_STREAMER_STAT_EN
  , output logic [CNT_WIDTH-1:0] words_o
`endif
);

  logic      inflight_q;
  skid_occ_t occ;
  logic [2:0] credit_used;
  logic      pop;

  // Words buffered plus the one in flight must leave room, so rdreq never depends on ready_i.
  assign credit_used  = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rdreq_o = !arst_i && enable_i && !fifo_empty_i && (credit_used < 3'(SKID_DEPTH));
  assign valid_o      = (occ != '0);
  assign pop          = valid_o && ready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) inflight_q <= 1'b0;
    else        inflight_q <= fifo_rdreq_o;
  end

  stream_skid_buf #(.DWIDTH(DWIDTH)) u_skid (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .push_i     (inflight_q),
    .push_dat_i (fifo_q_i),
    .pop_i      (pop),
    .occ_o      (occ),
    .dat_o      (data_o)
  );

`ifdef FIFO_RD_STREAMER_STAT_EN
  logic [CNT_WIDTH-1:0] words_q, words_d;

  assign words_d = pop ? words_q + CNT_WIDTH'(1) : words_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) words_q <= '0;
    else        words_q <= words_d;
  end

  assign words_o = words_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based fifo model plus count-based reference of the credit/latency rules.
module tb_fifo_rd_streamer;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          enable_i;
  logic [DW-1:0] fifo_q_i;
  logic          fifo_empty_i;
  logic          fifo_rdreq_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
`ifdef FIFO_RD_STREAMER_STAT_EN
  logic [CW-1:0] words_o;
`endif

  fifo_rd_streamer #(
    .DWIDTH(DW)
`ifdef FIFO_RD_STREAMER_STAT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .enable_i     (enable_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
`ifdef FIFO_RD_STREAMER_STAT_EN
    , .words_o    (words_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] fifo_mem[$];   // words sitting in the external fifo
  logic [DW-1:0] written_q[$];  // every word written and not yet delivered, in order
  int req_d1, req_d2, xfers;    // reads issued through last clk / the clk before, transfers so far
  int checks = 0, errors = 0;
  int max_out;
  logic last_rq, last_xfer, last_v;
  logic [DW-1:0] last_d;

  task automatic reset_model();
    fifo_mem.delete();
    written_q.delete();
    req_d1 = 0; req_d2 = 0; xfers = 0;
    fifo_empty_i = 1'b1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_mem.push_back(w);
    written_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  // One clock: sample at negedge, compare with the reference, then advance the fifo model after posedge.
  task automatic cycle();
    logic rq, v, exp_rq, exp_v;
    logic [DW-1:0] d;
    int outstanding, captured;
    @(negedge clk_i);
    rq = fifo_rdreq_o; v = valid_o; d = data_o;
    outstanding = req_d1 - xfers;
    captured    = req_d2 - xfers;
    if (outstanding > max_out) max_out = outstanding;
    exp_rq = enable_i && !fifo_empty_i && (outstanding < 3);
    exp_v  = (captured > 0);
    checks++;
    if (rq !== exp_rq) begin
      errors++;
      $display("FAIL rdreq: got %b expected %b (outstanding=%0d empty=%b en=%b)", rq, exp_rq, outstanding, fifo_empty_i, enable_i);
    end
    checks++;
    if (v !== exp_v) begin
      errors++;
      $display("FAIL valid: got %b expected %b (captured=%0d)", v, exp_v, captured);
    end
`ifdef FIFO_RD_STREAMER_STAT_EN
    checks++;
    if (words_o !== CW'(xfers)) begin
      errors++;
      $display("FAIL words_o: got %0d expected %0d", words_o, CW'(xfers));
    end
`endif
    if (v === 1'b1) begin
      checks++;
      if (written_q.size() == 0) begin
        errors++;
        $display("FAIL data: got 0x%02h expected no valid word", d);
      end else if (d !== written_q[0]) begin
        errors++;
        $display("FAIL data: got 0x%02h expected 0x%02h", d, written_q[0]);
      end
    end
    last_rq = rq; last_v = v; last_d = d;
    last_xfer = (v === 1'b1) && (ready_i === 1'b1);
    if (last_xfer) begin
      if (written_q.size() != 0) void'(written_q.pop_front());
      xfers++;
    end
    @(posedge clk_i);
    #1;
    req_d2 = req_d1;
    if (rq === 1'b1) req_d1++;
    if (rq === 1'b1 && fifo_mem.size() != 0) fifo_q_i = fifo_mem.pop_front();
    else                                     fifo_q_i = DW'($urandom);
    fifo_empty_i = (fifo_mem.size() == 0);
  endtask

  task automatic pulse_reset();
    #2;
    arst_i = 1'b1;
    #1;
    reset_model();
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
  endtask

  task automatic drain();
    enable_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 200 && (fifo_mem.size() != 0 || written_q.size() != 0); i++) cycle();
    checks++;
    if (written_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words undelivered, expected 0", written_q.size());
    end
  endtask

  task automatic test_reset();
    arst_i = 1'b1; enable_i = 1'b1; ready_i = 1'b0;
    fifo_q_i = 8'hEE; fifo_empty_i = 1'b0;
    #2;
    checks++;
    if (valid_o !== 1'b0 || fifo_rdreq_o !== 1'b0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_init: valid=%b rdreq=%b data=0x%02h expected 0 0 0x00", valid_o, fifo_rdreq_o, data_o);
    end
    reset_model();
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
    for (int i = 1; i <= 4; i++) fifo_write(DW'(8'hA0 + i));
    for (int i = 0; i < 3; i++) cycle();
    #2;
    arst_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || fifo_rdreq_o !== 1'b0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_midrun: valid=%b rdreq=%b data=0x%02h expected 0 0 0x00", valid_o, fifo_rdreq_o, data_o);
    end
    reset_model();
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_stream();
    int rq_first, rq_last, rq_n, x_first, x_last, x_n;
    rq_first = -1; rq_last = -1; rq_n = 0; x_first = -1; x_last = -1; x_n = 0;
    enable_i = 1'b1; ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (last_rq) begin if (rq_first < 0) rq_first = c; rq_last = c; rq_n++; end
      if (last_xfer) begin if (x_first < 0) x_first = c; x_last = c; x_n++; end
    end
    checks++;
    if (rq_n != 8 || rq_first != 0 || rq_last != 7) begin
      errors++;
      $display("FAIL stream_rdreq: n=%0d first=%0d last=%0d expected 8 0 7", rq_n, rq_first, rq_last);
    end
    checks++;
    if (x_n != 8 || x_first != 2 || x_last != 9) begin
      errors++;
      $display("FAIL stream_xfer: n=%0d first=%0d last=%0d expected 8 2 9", x_n, x_first, x_last);
    end
  endtask

  task automatic test_backpressure();
    int rq_n, x_first, x_last, x_n;
    rq_n = 0; x_first = -1; x_last = -1; x_n = 0;
    enable_i = 1'b1; ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (last_rq) rq_n++;
    end
    checks++;
    if (rq_n != 3) begin
      errors++;
      $display("FAIL bp_rdreq: got %0d reads expected 3", rq_n);
    end
    checks++;
    if (last_v !== 1'b1 || last_d !== 8'h01) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=0x%02h expected 1 0x01", last_v, last_d);
    end
    ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (last_xfer) begin if (x_first < 0) x_first = c; x_last = c; x_n++; end
    end
    checks++;
    if (x_n != 8 || x_first != 0 || x_last != 7) begin
      errors++;
      $display("FAIL bp_release: n=%0d first=%0d last=%0d expected 8 0 7", x_n, x_first, x_last);
    end
  endtask

  task automatic test_enable();
    int rq_n, x_n;
    rq_n = 0; x_n = 0;
    enable_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) fifo_write(DW'(8'h50 + i));
    cycle();
    checks++;
    if (last_rq !== 1'b1) begin
      errors++;
      $display("FAIL en_first: rdreq=%b expected 1", last_rq);
    end
    enable_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (last_rq) rq_n++;
      if (last_xfer) x_n++;
    end
    checks++;
    if (rq_n != 0 || x_n != 1) begin
      errors++;
      $display("FAIL en_low: reads=%0d xfers=%0d expected 0 1", rq_n, x_n);
    end
    drain();
  endtask

  task automatic test_random();
    int wr_n, start, c;
    wr_n = 0; start = xfers; c = 0; max_out = 0;
    enable_i = 1'b1;
    while ((xfers - start) < 1000 && c < 20000) begin
      if (wr_n < 1000 && $urandom_range(0, 99) < 60) begin
        fifo_write(DW'($urandom));
        wr_n++;
      end
      ready_i = ($urandom_range(0, 1) == 1);
      cycle();
      c++;
    end
    checks++;
    if ((xfers - start) != 1000) begin
      errors++;
      $display("FAIL random_count: delivered %0d expected 1000 (cycles=%0d)", xfers - start, c);
    end
    checks++;
    if (max_out > 3) begin
      errors++;
      $display("FAIL random_occ: max outstanding %0d expected <= 3", max_out);
    end
    drain();
  endtask

`ifdef FIFO_RD_STREAMER_STAT_EN
  task automatic test_stat();
    pulse_reset();
    for (int i = 0; i < 20; i++) fifo_write(DW'(i + 1));
    drain();
    checks++;
    if (words_o !== 4'd4) begin
      errors++;
      $display("FAIL stat_wrap: words_o=%0d expected 4", words_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_enable();
    test_random();
`ifdef FIFO_RD_STREAMER_STAT_EN
    test_stat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
